// File: rtl/xg_pcs_pkg.sv
// Shared 10GBASE-R PCS definitions for the xg0 transmit path.
// Contents: sync-header codes, idle block type, scrambler seed, gearbox pause
// sequence value and the 66-bit block struct used by the TX feeder and the
// scrambler bench models.
package xg_pcs_pkg;

    localparam logic [1:0]  SYNC_DATA         = 2'b01;
    localparam logic [1:0]  SYNC_CTRL         = 2'b10;
    localparam logic [1:0]  SYNC_INVALID      = 2'b00;
    localparam logic [7:0]  BLOCK_TYPE_IDLE   = 8'h1E;
    localparam logic [57:0] SCRAMBLER_INIT    = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [5:0]  GEARBOX_PAUSE_SEQ = 6'd32;
    // Sequence value whose phase-1 slot is not a load slot (next value is the pause)
    localparam logic [5:0]  GEARBOX_SKIP_SEQ  = GEARBOX_PAUSE_SEQ - 6'd1;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] pay;
    } xg_block_t;

    // Raw (unscrambled) idle control block
    localparam xg_block_t IDLE_BLOCK = '{hdr: SYNC_CTRL, pay: 64'(BLOCK_TYPE_IDLE)};

endpackage

// File: rtl/xg_scrambler64.sv
// Combinational 64-bit slice of the x^58+x^39+1 self-synchronous scrambler.
// Ports:
//   d      in  64  unscrambled payload, bit 0 first on the wire
//   s_in   in  58  history of scrambled bits, s_in[57] = most recent
//   q      out 64  scrambled payload
//   s_out  out 58  updated history (last 58 bits of q), s_out[57] = q[63]
module xg_scrambler64 (
    input  logic [63:0] d,
    input  logic [57:0] s_in,
    output logic [63:0] q,
    output logic [57:0] s_out
);

    // h[0..57] = prior history, h[58+i] = scrambled bit i. Bit i taps the bits
    // 39 and 58 positions earlier in the serial stream: h[i+19] and h[i].
    logic [121:0] h;

    always_comb begin
        h = {64'h0, s_in};
        for (int i = 0; i < 64; i++) begin
            h[i + 58] = d[i] ^ h[i + 19] ^ h[i];
        end
    end

    assign q     = h[121:58];
    assign s_out = h[121:64];

endmodule

// File: rtl/xg_tx_gearbox_feeder.sv
// 10GBASE-R TX PCS back end for SFP+ xg0: scrambles 66-bit blocks and feeds the
// GTX external 64b/66b gearbox 32 bits per cycle.
// Ports:
//   clk             TX user clock (32-bit datapath)
//   rst             synchronous active-high reset
//   blk_valid/blk_ready/blk_header/blk_data   upstream block handshake
//   tx_sequence/tx_header/tx_data             GTX gearbox interface
//   underrun        one-cycle pulse after a ready slot with no valid block
//   underrun_count  saturating count of underrun pulses
// Build option: XG_TX_IDLE_FILL_EN -- fill underrun slots with a scrambled idle
// control block; otherwise fill with an invalid sync header and S(0) payload.
module xg_tx_gearbox_feeder
    import xg_pcs_pkg::*;
#(
    parameter int SCRAMBLE    = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [1:0]             blk_header,
    input  logic [63:0]            blk_data,
    output logic [5:0]             tx_sequence,
    output logic [1:0]             tx_header,
    output logic [31:0]            tx_data,
    output logic                   underrun,
    output logic [COUNT_WIDTH-1:0] underrun_count
);

    logic [5:0]  seq;
    logic        phase;
    xg_block_t   hold;
    logic [57:0] scr;

    xg_block_t   load_blk;
    logic [63:0] scr_q;
    logic [57:0] scr_next;

    // Load slots are phase 1 of every seq except 31, so seq 32 is never loaded.
    assign blk_ready = phase && (seq != GEARBOX_SKIP_SEQ);

    always_comb begin
        load_blk = '{hdr: blk_header, pay: blk_data};
        if (!blk_valid) begin
`ifdef XG_TX_IDLE_FILL_EN
            load_blk = IDLE_BLOCK;
`else
            load_blk = '{hdr: SYNC_INVALID, pay: 64'h0};
`endif
        end
    end

    xg_scrambler64 u_scrambler (
        .d     (load_blk.pay),
        .s_in  (scr),
        .q     (scr_q),
        .s_out (scr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seq            <= '0;
            phase          <= 1'b0;
            hold           <= IDLE_BLOCK;
            scr            <= SCRAMBLER_INIT;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            phase    <= ~phase;
            underrun <= blk_ready && !blk_valid;
            if (phase) begin
                seq <= (seq == GEARBOX_PAUSE_SEQ) ? 6'd0 : seq + 6'd1;
            end
            // Scrambler history only moves on loads, including fill loads.
            if (blk_ready) begin
                if (SCRAMBLE != 0) begin
                    hold <= '{hdr: load_blk.hdr, pay: scr_q};
                    scr  <= scr_next;
                end else begin
                    hold <= load_blk;
                end
                if (!blk_valid && (underrun_count != '1)) begin
                    underrun_count <= underrun_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign tx_sequence = seq;
    assign tx_header   = hold.hdr;
    assign tx_data     = phase ? hold.pay[63:32] : hold.pay[31:0];

endmodule

// File: tb/tb_xg_tx_gearbox_feeder.sv
// Bench for xg_tx_gearbox_feeder: one scrambling instance (16-bit counter) and
// one raw instance (2-bit counter) share the stimulus; a cycle-indexed gearbox
// schedule plus a bit-serial scrambler model predicts every output.
module tb_xg_tx_gearbox_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blk_valid = 1'b0;
    logic [1:0]  blk_header = 2'b01;
    logic [63:0] blk_data = 64'h0;

    logic        rdy_s, rdy_r, und_s, und_r;
    logic [5:0]  seq_s, seq_r;
    logic [1:0]  hdr_s, hdr_r;
    logic [31:0] dat_s, dat_r;
    logic [15:0] cnt_s;
    logic [1:0]  cnt_r;

    always #5 clk = ~clk;

    xg_tx_gearbox_feeder #(.SCRAMBLE(1), .COUNT_WIDTH(16)) u_scr (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(rdy_s),
        .blk_header(blk_header), .blk_data(blk_data), .tx_sequence(seq_s),
        .tx_header(hdr_s), .tx_data(dat_s), .underrun(und_s), .underrun_count(cnt_s)
    );

    xg_tx_gearbox_feeder #(.SCRAMBLE(0), .COUNT_WIDTH(2)) u_raw (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(rdy_r),
        .blk_header(blk_header), .blk_data(blk_data), .tx_sequence(seq_r),
        .tx_header(hdr_r), .tx_data(dat_r), .underrun(und_r), .underrun_count(cnt_r)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          c;          // cycles since reset released
    logic [1:0]  m_hdr;
    logic [63:0] m_raw;      // payload as loaded (no scrambling)
    logic [63:0] m_scr;      // payload after bit-serial scrambling
    logic [57:0] lfsr;       // lfsr[0] = most recent scrambled bit
    logic        m_und;
    int          m_tot;
    bit          armed = 0;
    bit          counting = 0;
    int          hs = 0;
    int          max_seq = 0;

    task automatic scr_block(input logic [63:0] d, output logic [63:0] q);
        logic b;
        for (int i = 0; i < 64; i++) begin
            b    = d[i] ^ lfsr[38] ^ lfsr[57];
            q[i] = b;
            lfsr = {lfsr[56:0], b};
        end
    endtask

    function automatic bit exp_ready(input int cc);
        return (cc % 2 == 1) && (((cc / 2) % 33) != 31);
    endfunction

    // One clock cycle: check current outputs, apply inputs, advance the model.
    task automatic step(input bit r, input bit v, input logic [1:0] h, input logic [63:0] d);
        int          es;
        bit          ep, er;
        logic [63:0] q;
        es = (c / 2) % 33;
        ep = (c % 2 == 1);
        er = exp_ready(c);
        if (armed) begin
            chk("seq_s", 64'(seq_s), 64'(es));
            chk("seq_r", 64'(seq_r), 64'(es));
            chk("ready_s", 64'(rdy_s), 64'(er));
            chk("ready_r", 64'(rdy_r), 64'(er));
            chk("hdr_s", 64'(hdr_s), 64'(m_hdr));
            chk("hdr_r", 64'(hdr_r), 64'(m_hdr));
            chk("data_s", 64'(dat_s), 64'(ep ? m_scr[63:32] : m_scr[31:0]));
            chk("data_r", 64'(dat_r), 64'(ep ? m_raw[63:32] : m_raw[31:0]));
            chk("underrun_s", 64'(und_s), 64'(m_und));
            chk("underrun_r", 64'(und_r), 64'(m_und));
            chk("count_s", 64'(cnt_s), 64'((m_tot > 65535) ? 65535 : m_tot));
            chk("count_r", 64'(cnt_r), 64'((m_tot > 3) ? 3 : m_tot));
        end
        if (counting) begin
            if (rdy_s && v) hs++;
            if (int'(seq_s) > max_seq) max_seq = int'(seq_s);
        end
        rst        = r;
        blk_valid  = v;
        blk_header = h;
        blk_data   = d;
        if (r) begin
            c = 0; m_hdr = 2'b10; m_raw = 64'h1E; m_scr = 64'h1E;
            lfsr = '1; m_und = 1'b0; m_tot = 0;
        end else begin
            m_und = 1'b0;
            if (er) begin
                if (v) begin
                    m_hdr = h; m_raw = d;
                end else begin
`ifdef XG_TX_IDLE_FILL_EN
                    m_hdr = 2'b10; m_raw = 64'h1E;
`else
                    m_hdr = 2'b00; m_raw = 64'h0;
`endif
                    m_und = 1'b1;
                    m_tot++;
                end
                scr_block(m_raw, q);
                m_scr = q;
            end
            c++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int drops;
        @(negedge clk);
        repeat (3) step(1, 0, 2'b01, 64'h0);
        armed = 1;

        // Continuous incrementing data blocks over ten gearbox periods
        counting = 1;
        for (int n = 0; n < 660; n++) step(0, 1, 2'b01, 64'h0706050403020100 + 64'(n));
        counting = 0;
        chk("handshakes_660", 64'(hs), 64'd320);
        chk("max_seq_le_32", 64'(max_seq <= 32), 64'd1);

        // Random traffic with occasional underruns, data/control headers
        for (int n = 0; n < 400; n++)
            step(0, $urandom_range(0, 9) != 0, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
                 {$urandom, $urandom});

        // Reset at seq 17 phase 0, then all-zero data from the seed
        step(1, 0, 2'b01, 64'h0);
        for (int n = 0; n < 34; n++) step(0, 1, 2'b01, {$urandom, $urandom});
        chk("pre_rst_seq17", 64'(seq_s), 64'd17);
        step(1, 1, 2'b01, 64'h0);
        for (int n = 0; n < 200; n++) step(0, 1, 2'b01, 64'h0);

        // Five dropped slots from reset: raw counter saturates at 3
        step(1, 0, 2'b01, 64'h0);
        drops = 0;
        for (int n = 0; n < 40; n++) begin
            if (exp_ready(c) && drops < 5) begin
                drops++;
                step(0, 0, 2'b01, {$urandom, $urandom});
            end else begin
                step(0, 1, 2'b10, {$urandom, $urandom});
            end
        end
        chk("drop_count_sat2", 64'(cnt_r), 64'd3);
        chk("drop_count_16", 64'(cnt_s), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
